// File: rtl/demux_burst_sched.sv
// Round-robin burst scheduler driving the select lines of a 1:4 demux.
// Grants BURST beats at a time to enabled channels, with valid/ready flow control.
module demux_burst_sched #(
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    ch_en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [3:0]    out_ready,
    output logic [3:0]    out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    sel,
    output logic          busy,
    output logic          burst_done
);

    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    last_grant;
    logic [CW-1:0] cnt;
    logic [1:0]    next_grant;
    logic          beat;

    // First enabled channel after last_grant; last_grant itself has lowest priority.
    always_comb begin
        next_grant = last_grant;
        for (int k = 4; k >= 1; k--) begin
            if (ch_en[last_grant + 2'(k)]) begin
                next_grant = last_grant + 2'(k);
            end
        end
    end

    assign beat     = (state == XFER) && in_valid && out_ready[sel];
    assign in_ready = (state == XFER) && out_ready[sel];
    assign out_data = in_data;

    always_comb begin
        out_valid = 4'b0000;
        if (state == XFER) begin
            out_valid[sel] = in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 2'd0;
            last_grant <= 2'd3;
            cnt        <= '0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    // ch_en only matters here, so mid-burst mask changes wait for the next grant
                    if (in_valid && (ch_en != 4'b0000)) begin
                        state      <= XFER;
                        busy       <= 1'b1;
                        sel        <= next_grant;
                        last_grant <= next_grant;
                        cnt        <= '0;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (cnt == CNT_LAST) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            cnt        <= '0;
                            burst_done <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_burst_sched.sv
// Self-checking bench for demux_burst_sched against a burst-level behavioural model.
module tb_demux_burst_sched;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ch_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [1:0] sel;
    logic       busy;
    logic       burst_done;

    int checks = 0;
    int failures = 0;

    // Model: a burst is either open (with beats remaining) or not.
    bit m_busy;
    int m_grant;
    int m_last;
    int m_left;
    bit m_done;

    logic [16:0] exp_v;
    logic [16:0] obs_v;
    bit          was_busy;
    int          grants[$];
    int          got[4][$];
    int          done_cnt;

    demux_burst_sched #(.DW(8), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .sel(sel), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    function automatic int pick(int last, logic [3:0] en);
        for (int k = 1; k <= 4; k++) begin
            if (en[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_last = 3; m_left = 0; m_done = 0;
    endtask

    task automatic clear_logs();
        grants.delete();
        for (int i = 0; i < 4; i++) got[i].delete();
        was_busy = 0;
        done_cnt = 0;
    endtask

    // Let inputs settle, then form expected and observed output vectors and log deliveries.
    task automatic observe();
        logic [3:0] ev;
        logic       er;
        #1;
        ev = (m_busy && in_valid) ? 4'(1 << m_grant) : 4'b0000;
        er = m_busy && out_ready[m_grant];
        exp_v = {2'(m_grant), m_busy, m_done, er, ev, in_data};
        obs_v = {sel, busy, burst_done, in_ready, out_valid, out_data};
        if (busy && !was_busy) grants.push_back(int'(sel));
        was_busy = busy;
        if (burst_done) done_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (out_valid[i] && out_ready[i]) got[i].push_back(int'(out_data));
        end
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic tick(output bit b);
        int p;
        b = rst_n && m_busy && in_valid && out_ready[m_grant];
        if (!rst_n) begin
            model_reset();
        end else begin
            m_done = 0;
            if (!m_busy) begin
                p = pick(m_last, ch_en);
                if (in_valid && p >= 0) begin
                    m_busy = 1; m_grant = p; m_last = p; m_left = BURST;
                end
            end else if (b) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bit b;
        rst_n = 0; ch_en = 4'b0; in_valid = 0; in_data = 8'd0; out_ready = 4'b0;
        model_reset();
        tick(b);
        tick(b);
        rst_n = 1;
        clear_logs();
    endtask

    task automatic test_reset();
        bit b;
        rst_n = 0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            ch_en = 4'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom);
            out_ready = 4'($urandom);
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
        end
        clear_logs();
        ch_en = 4'b1111; in_valid = 1; out_ready = 4'b1111; in_data = 8'd0;
        rst_n = 1;
        for (int c = 0; c < 2; c++) begin
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
        end
        checks++;
        if (grants.size() != 1 || grants[0] != 0) begin
            failures++; $display("FAIL first_grant got=%0d n=%0d exp=0", grants[0], grants.size());
        end
    endtask

    task automatic test_rotation();
        bit b;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        ch_en = 4'b1111; in_valid = 1; out_ready = 4'b1111; in_data = 8'd0;
        for (int c = 0; c < 25; c++) begin
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL rotation cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
            if (b) in_data = in_data + 8'd1;
        end
        checks++;
        if (grants.size() != 5) begin
            failures++; $display("FAIL rotation_ngrants got=%0d exp=5", grants.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (grants[i] != exp_g[i]) begin
                failures++; $display("FAIL rotation_grant i=%0d got=%0d exp=%0d", i, grants[i], exp_g[i]);
            end
        end
        for (int ch = 0; ch < 4; ch++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (got[ch][j] != ch * 4 + j) begin
                    failures++;
                    $display("FAIL rotation_data ch=%0d j=%0d got=%0d exp=%0d", ch, j, got[ch][j], ch * 4 + j);
                end
            end
        end
        checks++;
        if (done_cnt != 4) begin
            failures++; $display("FAIL rotation_done_pulses got=%0d exp=4", done_cnt);
        end
    endtask

    task automatic test_sparse();
        bit b;
        int exp_a[4] = '{1, 3, 1, 3};
        apply_reset();
        ch_en = 4'b1010; in_valid = 1; out_ready = 4'b1111; in_data = 8'd0;
        for (int c = 0; c < 20; c++) begin
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL sparse_a cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grants[i] != exp_a[i]) begin
                failures++; $display("FAIL sparse_a_grant i=%0d got=%0d exp=%0d", i, grants[i], exp_a[i]);
            end
        end
        apply_reset();
        ch_en = 4'b0100; in_valid = 1; out_ready = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL sparse_b cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
        end
        checks++;
        if (grants.size() != 3 || grants[0] != 2 || grants[1] != 2 || grants[2] != 2) begin
            failures++; $display("FAIL sparse_b_grant n=%0d first=%0d exp=3x2", grants.size(), grants[0]);
        end
    endtask

    // Stall after beat 2 on channel 2, by consumer ready (mode 0) or producer valid (mode 1).
    task automatic test_backpressure(input int mode);
        bit b;
        bit stall;
        apply_reset();
        ch_en = 4'b0100; in_data = 8'd0;
        for (int c = 0; c < 9; c++) begin
            stall = (c >= 3 && c <= 5);
            in_valid = !(mode == 1 && stall);
            out_ready = (mode == 0 && stall) ? 4'b1011 : 4'b1111;
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL backpressure%0d cyc=%0d got=%h exp=%h", mode, c, obs_v, exp_v);
            end
            tick(b);
            if (b) in_data = in_data + 8'd1;
        end
        checks++;
        if (got[2].size() != 4) begin
            failures++; $display("FAIL backpressure%0d_count got=%0d exp=4", mode, got[2].size());
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[2][j] != j) begin
                failures++; $display("FAIL backpressure%0d_data j=%0d got=%0d exp=%0d", mode, j, got[2][j], j);
            end
        end
    endtask

    task automatic test_mask_change();
        bit b;
        apply_reset();
        ch_en = 4'b1111; in_valid = 1; out_ready = 4'b1111; in_data = 8'd0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) ch_en = 4'b0000;
            if (c == 9) ch_en = 4'b1111;
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL mask_change cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
            if (b) in_data = in_data + 8'd1;
        end
        checks++;
        if (got[0].size() != 4 || done_cnt != 1) begin
            failures++; $display("FAIL mask_change_burst beats=%0d done=%0d exp=4,1", got[0].size(), done_cnt);
        end
        checks++;
        if (grants.size() != 2 || grants[1] != 1) begin
            failures++; $display("FAIL mask_change_resume n=%0d grant=%0d exp=1", grants.size(), grants[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit b;
        apply_reset();
        ch_en = 4'b1111; in_valid = 1; out_ready = 4'b1111; in_data = 8'd0;
        for (int c = 0; c < 8; c++) begin
            observe();
            tick(b);
            if (b) in_data = in_data + 8'd1;
        end
        checks++;
        if (got[1].size() != 2) begin
            failures++; $display("FAIL reset_mid_setup got=%0d exp=2", got[1].size());
        end
        rst_n = 0;
        model_reset();
        observe();
        checks++;
        if (obs_v !== exp_v) begin
            failures++; $display("FAIL reset_mid_async got=%h exp=%h", obs_v, exp_v);
        end
        tick(b);
        rst_n = 1;
        clear_logs();
        for (int c = 0; c < 6; c++) begin
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
            if (b) in_data = in_data + 8'd1;
        end
        checks++;
        if (grants.size() != 1 || grants[0] != 0 || got[0].size() != 4) begin
            failures++;
            $display("FAIL reset_mid_regrant grant=%0d beats=%0d exp=0,4", grants[0], got[0].size());
        end
    endtask

    task automatic test_random();
        bit b;
        apply_reset();
        ch_en = 4'($urandom);
        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = 4'($urandom);
            in_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
            observe();
            checks++;
            if (obs_v !== exp_v) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            tick(b);
        end
    endtask

    initial begin
        rst_n = 0; ch_en = 4'b0; in_valid = 0; in_data = 8'd0; out_ready = 4'b0;
        model_reset();
        clear_logs();
        #2;
        test_reset();
        test_rotation();
        test_sparse();
        test_backpressure(0);
        test_backpressure(1);
        test_mask_change();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
